// File: rtl/ram_port_arbiter.sv
// Round-robin share of one synchronous RAM port; ack 2 cycles after the grant edge.
// No backpressure: requesters hold req/we/addr/wdata until their one-cycle ack.
module ram_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REQ    = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  input  logic [DATA_WIDTH-1:0]         ram_dout,
  output logic                          busy
);

  localparam int IDW = $clog2(NUM_REQ);

  logic [IDW-1:0]        last_grant;
  logic                  s1_valid, s2_valid;
  logic [IDW-1:0]        s1_id, s2_id;
  logic [NUM_REQ-1:0]    elig;
  logic                  grant_vld;
  logic [IDW-1:0]        grant_id;
  logic [IDW-1:0]        cand;
  logic                  g_we;
  logic [ADDR_WIDTH-1:0] g_addr;
  logic [DATA_WIDTH-1:0] g_din;

  // An id still in S1 or S2 is masked so a held req is not re-granted before its ack retires.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i] = req[i] && !(s1_valid && s1_id == IDW'(i)) && !(s2_valid && s2_id == IDW'(i));
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_vld && elig[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    g_we   = 1'b0;
    g_addr = '0;
    g_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == IDW'(i)) begin
        g_we   = we[i];
        g_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        g_din  = wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s2_valid   <= 1'b0;
      s2_id      <= '0;
      last_grant <= IDW'(NUM_REQ - 1);
    end else begin
      if (grant_vld) begin
        ram_we     <= g_we;
        ram_addr   <= g_addr;
        ram_din    <= g_din;
        s1_valid   <= 1'b1;
        s1_id      <= grant_id;
        last_grant <= grant_id;
      end else begin
        ram_we   <= 1'b0;
        s1_valid <= 1'b0;
      end
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
    end
  end

  // S2 aligns with the RAM's registered output, so completion is combinational from it.
  always_comb begin
    ack   = '0;
    rdata = '0;
    if (s2_valid) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        ack[i] = (s2_id == IDW'(i));
      end
      rdata = ram_dout;
    end
  end

  assign busy = s1_valid | s2_valid;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a write-first, one-cycle-latency RAM model.
module tb_ram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, we;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [3:0]  ack;
  logic [7:0]  rdata;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_din;
  logic [7:0]  ram_dout;
  logic        busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:65535];

  ram_port_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .NUM_REQ(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      ram_dout      <= ram_din;
    end else begin
      ram_dout <= mem[ram_addr];
    end
  end

  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [3:0]  e_ack;
    logic [7:0]  e_rdata;
    logic        e_busy;
    logic        e_ram_we;
    logic [15:0] e_ram_addr;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(logic [3:0] rq, logic [3:0] w, logic [63:0] a, logic [31:0] d,
                              logic [3:0] ea, logic [7:0] er, logic eb, logic ew, logic [15:0] eaddr);
    vec_t v;
    v.req = rq; v.we = w; v.addr = a; v.wdata = d;
    v.e_ack = ea; v.e_rdata = er; v.e_busy = eb; v.e_ram_we = ew; v.e_ram_addr = eaddr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_ack, input logic [7:0] e_rdata,
                         input logic e_busy, input logic e_ram_we, input logic [15:0] e_ram_addr);
    chk({tag, ".ack"}, 64'(ack), 64'(e_ack));
    chk({tag, ".rdata"}, 64'(rdata), 64'(e_rdata));
    chk({tag, ".busy"}, 64'(busy), 64'(e_busy));
    chk({tag, ".ram_we"}, 64'(ram_we), 64'(e_ram_we));
    chk({tag, ".ram_addr"}, 64'(ram_addr), 64'(e_ram_addr));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    mem[16'h0100] = 8'h11;
    mem[16'h0101] = 8'h22;
    mem[16'h0102] = 8'h33;
    mem[16'h0103] = 8'h44;

    // single read by 2, write/read by 1, idle, then 2+3 contention from last_grant=1
    vecs[0]  = mk(4'b0100, 4'b0000, 64'h0000_1234_0000_0000, 32'h0, 4'b0000, 8'h00, 1, 0, 16'h1234);
    vecs[1]  = mk(4'b0100, 4'b0000, 64'h0000_1234_0000_0000, 32'h0, 4'b0100, 8'hA5, 1, 0, 16'h1234);
    vecs[2]  = mk(4'b0100, 4'b0000, 64'h0000_1234_0000_0000, 32'h0, 4'b0000, 8'h00, 0, 0, 16'h1234);
    vecs[3]  = mk(4'b0000, 4'b0000, 64'h0, 32'h0, 4'b0000, 8'h00, 0, 0, 16'h1234);
    vecs[4]  = mk(4'b0010, 4'b0010, 64'h0000_0000_0010_0000, 32'h0000_5A00, 4'b0000, 8'h00, 1, 1, 16'h0010);
    vecs[5]  = mk(4'b0010, 4'b0010, 64'h0000_0000_0010_0000, 32'h0000_5A00, 4'b0010, 8'h5A, 1, 0, 16'h0010);
    vecs[6]  = mk(4'b0000, 4'b0000, 64'h0, 32'h0, 4'b0000, 8'h00, 0, 0, 16'h0010);
    vecs[7]  = mk(4'b0010, 4'b0000, 64'h0000_0000_0010_0000, 32'h0, 4'b0000, 8'h00, 1, 0, 16'h0010);
    vecs[8]  = mk(4'b0010, 4'b0000, 64'h0000_0000_0010_0000, 32'h0, 4'b0010, 8'h5A, 1, 0, 16'h0010);
    vecs[9]  = mk(4'b0000, 4'b0000, 64'h0, 32'h0, 4'b0000, 8'h00, 0, 0, 16'h0010);
    vecs[10] = mk(4'b0000, 4'b0000, 64'h0, 32'h0, 4'b0000, 8'h00, 0, 0, 16'h0010);
    vecs[11] = mk(4'b1100, 4'b0000, 64'h0102_0101_0000_0000, 32'h0, 4'b0000, 8'h00, 1, 0, 16'h0101);
    vecs[12] = mk(4'b1100, 4'b0000, 64'h0102_0101_0000_0000, 32'h0, 4'b0100, 8'h22, 1, 0, 16'h0102);
    vecs[13] = mk(4'b1000, 4'b0000, 64'h0102_0101_0000_0000, 32'h0, 4'b1000, 8'h33, 1, 0, 16'h0102);
    vecs[14] = mk(4'b0000, 4'b0000, 64'h0, 32'h0, 4'b0000, 8'h00, 0, 0, 16'h0102);

    rst_n = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_out("reset", 4'b0000, 8'h00, 0, 0, 16'h0000);
    chk("reset.ram_din", 64'(ram_din), 64'h0);
    rst_n = 1'b1;

    for (int n = 0; n < 15; n++) begin
      req = vecs[n].req; we = vecs[n].we; addr = vecs[n].addr; wdata = vecs[n].wdata;
      @(posedge clk);
      @(negedge clk);
      chk_out($sformatf("vec%0d", n), vecs[n].e_ack, vecs[n].e_rdata, vecs[n].e_busy,
              vecs[n].e_ram_we, vecs[n].e_ram_addr);
    end

    // Four simultaneous reads from reset: grants 0,1,2,3 on consecutive edges.
    rst_n = 1'b0; req = 4'b1111; we = '0;
    addr = 64'h0103_0102_0101_0100;
    @(posedge clk);
    @(negedge clk);
    chk("rr4.reset_ack", 64'(ack), 64'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk_out($sformatf("rr4.c%0d", c),
              (c >= 1 && c <= 4) ? 4'(1 << (c - 1)) : 4'b0000,
              (c >= 1 && c <= 4) ? 8'(8'h11 * c) : 8'h00,
              c <= 4, 0, (c <= 3) ? 16'(16'h0100 + c) : 16'h0103);
      req = req & ~ack;
    end

    // Requesters 0 and 3 held high: period-3 interleave, never re-granted while in flight.
    req = 4'b1001; we = '0;
    addr = 64'h0103_0000_0000_1234;
    for (int c = 0; c < 9; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk_out($sformatf("hold.c%0d", c),
              (c % 3 == 1) ? 4'b0001 : (c % 3 == 2 && c > 0) ? 4'b1000 : 4'b0000,
              (c % 3 == 1) ? 8'hA5 : (c % 3 == 2) ? 8'h44 : 8'h00,
              1, 0, (c % 3 == 0) ? 16'h1234 : 16'h0103);
    end
    req = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("hold.drain_busy", 64'(busy), 64'h0);

    // Reset while a write sits on the RAM port.
    req = 4'b0010; we = 4'b0010;
    addr = 64'h0000_0000_0020_0000; wdata = 32'h0000_7700;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wr.ram_we", 64'(ram_we), 64'h1);
    chk("rst_wr.ram_addr", 64'(ram_addr), 64'h0020);
    chk("rst_wr.ram_din", 64'(ram_din), 64'h77);
    rst_n = 1'b0; req = '0; we = '0; wdata = '0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk_out($sformatf("rst_wr.in_reset%0d", c), 4'b0000, 8'h00, 0, 0, 16'h0000);
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_out("rst_wr.released", 4'b0000, 8'h00, 0, 0, 16'h0000);
    req = 4'b0011;
    addr = 64'h0000_0000_0100_0020;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk_out($sformatf("rst_wr.after%0d", c),
              (c == 1) ? 4'b0001 : (c == 2) ? 4'b0010 : 4'b0000,
              (c == 1) ? 8'h77 : (c == 2) ? 8'h11 : 8'h00,
              c <= 2, 0, (c == 0) ? 16'h0020 : 16'h0100);
      req = req & ~ack;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
